// File: rtl/mcast_fork_buf_if.sv
// Handshake bundle between the router output stage, the fork buffer and its destinations.
interface mcast_fork_buf_if #(
  parameter int unsigned NUM_PORTS  = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]  in_sel;
  logic                  in_ready;
  logic [NUM_PORTS-1:0]  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]  out_ready;
  logic                  busy;
  logic                  sel_err;

  // Environment side: drives the upstream flit and the destination readies.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, busy, sel_err
  );

  // Fork buffer side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, busy, sel_err
  );
endinterface

// File: rtl/mcast_fork_buf.sv
// One-entry holding register that forks a flit to a multi-hot set of destinations.
// EAGER=1 lets each destination drain on its own cycle; EAGER=0 needs all selected
// destinations ready together.
module mcast_fork_buf #(
  parameter int unsigned NUM_PORTS   = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MULTI_READY = 1,
  parameter int unsigned EAGER       = 1
) (
  input logic             clk,
  input logic             rst,
  mcast_fork_buf_if.slave bus
);

  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [NUM_PORTS-1:0]  pending;
  logic                  sel_err_q;

  logic                  sel_legal;
  logic                  all_rdy;
  logic                  drain_done;
  logic                  in_ready_w;
  logic                  take;
  logic [NUM_PORTS-1:0]  out_valid_w;
  logic [NUM_PORTS-1:0]  pending_nxt;

  // Mask legality: empty mask never allowed, multi-hot only when MULTI_READY is set.
  always_comb begin
    sel_legal = (bus.in_sel != '0);
    if (MULTI_READY == 0) begin
      sel_legal = sel_legal && ((bus.in_sel & (bus.in_sel - NUM_PORTS'(1))) == '0);
    end
  end

  // Drain detection, per-destination valid and the pending mask for a held flit.
  always_comb begin
    all_rdy    = &(~pending | bus.out_ready);
    drain_done = hold_valid & all_rdy;
    in_ready_w = ~hold_valid | drain_done;
    take       = bus.in_valid & in_ready_w;
    if (EAGER != 0) begin
      out_valid_w = {NUM_PORTS{hold_valid}} & pending;
      pending_nxt = pending & ~(bus.out_ready & out_valid_w);
    end else begin
      out_valid_w = {NUM_PORTS{hold_valid & all_rdy}} & pending;
      pending_nxt = all_rdy ? '0 : pending;
    end
  end

  // Holding register: refill takes priority over drain; illegal masks are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      pending    <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      sel_err_q <= take & ~sel_legal;
      if (take) begin
        hold_valid <= sel_legal;
        pending    <= sel_legal ? bus.in_sel : '0;
        if (sel_legal) begin
          hold_data <= bus.in_data;
        end
      end else if (hold_valid) begin
        hold_valid <= ~drain_done;
        pending    <= pending_nxt;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = hold_data;
  assign bus.busy      = hold_valid;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mcast_fork_buf.sv
// Directed bench for mcast_fork_buf: eager, lockstep and one-hot-only instances.
module tb_mcast_fork_buf;
  localparam int unsigned NP = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mcast_fork_buf_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) a ();
  mcast_fork_buf_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) b ();
  mcast_fork_buf_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) c ();

  mcast_fork_buf #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MULTI_READY(1), .EAGER(1))
    ua (.clk(clk), .rst(rst), .bus(a));
  mcast_fork_buf #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MULTI_READY(1), .EAGER(0))
    ub (.clk(clk), .rst(rst), .bus(b));
  mcast_fork_buf #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MULTI_READY(0), .EAGER(1))
    uc (.clk(clk), .rst(rst), .bus(c));

  typedef struct {
    logic [DW-1:0] data;
    logic [NP-1:0] mask;
  } flit_t;

  flit_t         exp_q[$];
  logic [NP-1:0] seen = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [DW-1:0] d, input logic [NP-1:0] m);
    flit_t f;
    f.data = d;
    f.mask = m;
    exp_q.push_back(f);
  endtask

  // Scoreboard on the eager instance: every handshake must match the oldest
  // expected flit, on a selected port, exactly once.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NP); i++) begin
        if (a.out_valid[i] && a.out_ready[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected port=%0d obs=delivery exp=none", i);
          end else begin
            chk("sb_data", a.out_data, exp_q[0].data);
            chk("sb_port_once", 32'(exp_q[0].mask[i] & ~seen[i]), 32'd1);
            seen[i] = 1'b1;
          end
        end
      end
      if (exp_q.size() != 0 && (seen & exp_q[0].mask) == exp_q[0].mask) begin
        void'(exp_q.pop_front());
        seen = '0;
      end
    end
  end

  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.in_sel = '0; a.out_ready = '0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_sel = '0; b.out_ready = '0;
    c.in_valid = 1'b0; c.in_data = '0; c.in_sel = '0; c.out_ready = '0;

    // Reset state
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("rst_busy", 32'(a.busy), 32'd0);
    chk("rst_in_ready", 32'(a.in_ready), 32'd1);
    chk("rst_sel_err", 32'(a.sel_err), 32'd0);
    chk("rst_out_data", a.out_data, 32'd0);
    cyc();
    rst = 1'b0;

    // Single unicast flit
    a.in_valid = 1'b1; a.in_data = 32'hA5A5_0001; a.in_sel = 5'b00100; a.out_ready = 5'b11111;
    push_a(32'hA5A5_0001, 5'b00100);
    @(negedge clk);
    chk("uni_in_ready", 32'(a.in_ready), 32'd1);
    cyc();
    a.in_valid = 1'b0;
    @(negedge clk);
    chk("uni_out_valid", 32'(a.out_valid), 32'(5'b00100));
    chk("uni_out_data", a.out_data, 32'hA5A5_0001);
    chk("uni_busy", 32'(a.busy), 32'd1);
    cyc();
    @(negedge clk);
    chk("uni_busy_drop", 32'(a.busy), 32'd0);
    chk("uni_valid_drop", 32'(a.out_valid), 32'd0);
    cyc();

    // Eager multicast with staggered readies
    a.in_valid = 1'b1; a.in_data = 32'h0000_0002; a.in_sel = 5'b10011; a.out_ready = '0;
    push_a(32'h0000_0002, 5'b10011);
    cyc();
    a.in_valid = 1'b0; a.in_sel = 5'b01100; a.out_ready = 5'b00001;
    @(negedge clk);
    chk("eag_ov_c1", 32'(a.out_valid), 32'(5'b10011));
    chk("eag_rdy_c1", 32'(a.in_ready), 32'd0);
    cyc();
    a.out_ready = 5'b10000;
    @(negedge clk);
    chk("eag_ov_c2", 32'(a.out_valid), 32'(5'b10010));
    chk("eag_rdy_c2", 32'(a.in_ready), 32'd0);
    cyc();
    a.out_ready = 5'b00010;
    @(negedge clk);
    chk("eag_ov_c3", 32'(a.out_valid), 32'(5'b00010));
    chk("eag_rdy_c3", 32'(a.in_ready), 32'd1);
    cyc();
    a.out_ready = '0;
    @(negedge clk);
    chk("eag_ov_c4", 32'(a.out_valid), 32'd0);
    chk("eag_busy_c4", 32'(a.busy), 32'd0);
    cyc();

    // Lockstep: no valid until every selected destination is ready
    b.in_valid = 1'b1; b.in_data = 32'h0000_0003; b.in_sel = 5'b00110; b.out_ready = 5'b00100;
    cyc();
    b.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lck_ov_wait", 32'(b.out_valid), 32'd0);
      chk("lck_busy_wait", 32'(b.busy), 32'd1);
      cyc();
    end
    b.out_ready = 5'b00110;
    @(negedge clk);
    chk("lck_ov_fire", 32'(b.out_valid), 32'(5'b00110));
    chk("lck_data", b.out_data, 32'h0000_0003);
    cyc();
    @(negedge clk);
    chk("lck_ov_after", 32'(b.out_valid), 32'd0);
    chk("lck_busy_after", 32'(b.busy), 32'd0);
    cyc();

    // Back-to-back throughput on one destination
    a.out_ready = 5'b01000;
    for (int k = 0; k < 8; k++) begin
      a.in_valid = 1'b1; a.in_data = 32'(k); a.in_sel = 5'b01000;
      push_a(32'(k), 5'b01000);
      @(negedge clk);
      chk("thr_in_ready", 32'(a.in_ready), 32'd1);
      if (k > 0) begin
        chk("thr_out_data", a.out_data, 32'(k - 1));
        chk("thr_out_valid", 32'(a.out_valid), 32'(5'b01000));
      end
      cyc();
    end
    a.in_valid = 1'b0;
    @(negedge clk);
    chk("thr_last_data", a.out_data, 32'd7);
    chk("thr_last_valid", 32'(a.out_valid), 32'(5'b01000));
    cyc();
    @(negedge clk);
    chk("thr_busy_end", 32'(a.busy), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    cyc();

    // Illegal multi-hot mask on the one-hot-only instance
    c.in_valid = 1'b1; c.in_data = 32'hDEAD_0001; c.in_sel = 5'b00011; c.out_ready = 5'b11111;
    @(negedge clk);
    chk("ill_mh_in_ready", 32'(c.in_ready), 32'd1);
    cyc();
    c.in_valid = 1'b0;
    @(negedge clk);
    chk("ill_mh_sel_err", 32'(c.sel_err), 32'd1);
    chk("ill_mh_out_valid", 32'(c.out_valid), 32'd0);
    chk("ill_mh_busy", 32'(c.busy), 32'd0);
    cyc();
    @(negedge clk);
    chk("ill_mh_sel_err_end", 32'(c.sel_err), 32'd0);

    // One-hot mask is legal on the same instance
    cyc();
    c.in_valid = 1'b1; c.in_data = 32'h0000_0011; c.in_sel = 5'b00001;
    cyc();
    c.in_valid = 1'b0;
    @(negedge clk);
    chk("oh_out_valid", 32'(c.out_valid), 32'(5'b00001));
    chk("oh_sel_err", 32'(c.sel_err), 32'd0);
    cyc();

    // Empty mask is illegal in multi-hot mode too
    a.in_valid = 1'b1; a.in_data = 32'hDEAD_0002; a.in_sel = '0; a.out_ready = 5'b11111;
    cyc();
    a.in_valid = 1'b0;
    @(negedge clk);
    chk("ill_zero_sel_err", 32'(a.sel_err), 32'd1);
    chk("ill_zero_out_valid", 32'(a.out_valid), 32'd0);
    chk("ill_zero_busy", 32'(a.busy), 32'd0);
    cyc();
    @(negedge clk);
    chk("ill_zero_sel_err_end", 32'(a.sel_err), 32'd0);
    cyc();

    // Reset in the middle of a multicast
    a.in_valid = 1'b1; a.in_data = 32'h0000_0006; a.in_sel = 5'b11111; a.out_ready = '0;
    push_a(32'h0000_0006, 5'b11111);
    cyc();
    a.in_valid = 1'b0; a.out_ready = 5'b00001;
    @(negedge clk);
    chk("mid_ov", 32'(a.out_valid), 32'(5'b11111));
    cyc();
    a.out_ready = '0;
    rst = 1'b1;
    exp_q.delete();
    seen = '0;
    cyc();
    rst = 1'b0;
    a.out_ready = 5'b11111;
    @(negedge clk);
    chk("mid_rst_ov", 32'(a.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(a.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(a.in_ready), 32'd1);
    for (int k = 0; k < 3; k++) cyc();
    @(negedge clk);
    chk("mid_rst_quiet", 32'(a.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcast_fork_buf.md
Name: mcast_fork_buf

Overview:
- Parametrised successor to the router's 5-to-1 ready-collapse mux.
- Buffers one flit from a router output stage and forks it to NUM_PORTS destinations selected by a one-hot or multi-hot mask.
- Ready is no longer collapsed combinationally. A per-destination pending mask lets each destination take the flit on its own cycle (eager multicast).
- A lockstep mode keeps the legacy behaviour, where every selected destination must be ready in the same cycle.

Parameters:
- NUM_PORTS, 5, number of destination channels (2..16).
- DATA_WIDTH, 32, flit width in bits.
- MULTI_READY, 1: 1 means multi-hot sel is legal; 0 means sel must be one-hot.
- EAGER, 1: 1 means destinations drain independently; 0 means lockstep (all selected ready together).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream flit valid.
- in_data  input  DATA_WIDTH  upstream flit.
- in_sel  input  NUM_PORTS  destination mask, sampled with the flit.
- in_ready  output  1  holding register can accept this cycle.
- out_valid  output  NUM_PORTS  per-destination valid.
- out_data  output  DATA_WIDTH  held flit, shared by all destinations.
- out_ready  input  NUM_PORTS  per-destination ready.
- busy  output  1  holding register occupied.
- sel_err  output  1  one-cycle pulse when an illegal mask is accepted.

Behaviour:
- One-entry holding register: hold_valid, hold_data, pending[NUM_PORTS-1:0].
- Reset values, cycle after rst=1: hold_valid=0, pending=0, hold_data=0, sel_err=0. Hence out_valid=0, busy=0, in_ready=1.
- rst mid-operation discards the held flit and its pending mask. No partial delivery is completed.
- out_data = hold_data at all times. busy = hold_valid.
- Take a flit: a flit is taken on the rising edge where in_valid & in_ready.
- Latency: 1 cycle from acceptance to out_valid. There is no combinational path from in_* to out_*.
- Mask legality:
  - in_sel==0 is always illegal.
  - With MULTI_READY=0, a non-one-hot mask is illegal.
  - An illegal flit is still accepted (in_ready honoured) but discarded: hold_valid stays/becomes 0, and sel_err=1 for exactly the next cycle.
- EAGER=1:
  - out_valid[i] = hold_valid & pending[i]. Valid never depends on ready.
  - Each cycle, pending <= pending & ~(out_ready & out_valid).
  - Drain completes in the cycle where (pending & ~out_ready)==0; hold_valid then clears unless it is refilled.
- EAGER=0 (lockstep):
  - all_rdy = &(~pending | out_ready).
  - out_valid[i] = hold_valid & pending[i] & all_rdy. Valid depends on ready; this is a legacy-compatible combinational path.
  - pending clears wholesale when all_rdy & hold_valid.
- in_ready = ~hold_valid | drain_done, where drain_done is the same-cycle completion condition above. Back-to-back flits therefore sustain 1 flit/cycle when all selected destinations are ready.
- Simultaneous drain and accept in the same cycle: the new flit's data and mask overwrite the register. hold_valid stays 1 (legal mask) or drops to 0 (illegal mask).
- A destination that has already taken the flit (pending[i]=0) sees out_valid[i]=0 until the next flit, even if the others are still pending.
- in_sel bits are captured only at acceptance. Changes to in_sel while the register is held have no effect.

Test Plan:
- Reset, EAGER=1, NUM_PORTS=5. After reset deassert, send data=0xA5A5_0001, sel=5'b00100, out_ready=5'b11111.
  -> in_ready=1 after reset.
  -> out_valid=5'b00100 one cycle later, out_data=0xA5A5_0001.
  -> busy drops the cycle after the handshake.
- Eager multicast: sel=5'b10011. Drive out_ready=5'b00001 in cycle 1, 5'b10000 in cycle 2, 5'b00010 in cycle 3.
  -> out_valid goes 10011 -> 10010 -> 00010 -> 00000.
  -> in_ready=0 in cycles 1-2 and 1 in cycle 3.
  -> exactly one delivery per destination.
- Lockstep (EAGER=0): sel=5'b00110, out_ready=5'b00100 for 3 cycles, then 5'b00110.
  -> out_valid=0 for the 3 cycles, then 5'b00110 for exactly 1 cycle, then the register empties.
- Throughput: 8 back-to-back flits (data 0..7), sel=5'b01000, out_ready[3]=1 constant.
  -> in_ready stays 1.
  -> out_data sequence 0..7 on consecutive cycles, with no bubbles.
- Illegal masks:
  - MULTI_READY=0, sel=5'b00011 -> accepted, no out_valid, sel_err high for 1 cycle.
  - Any mode, sel=0 -> same response.
- Reset mid-delivery: sel=5'b11111, only out_ready[0]=1 for one cycle, then rst=1.
  -> the next cycle shows out_valid=0, busy=0, in_ready=1.
  -> no further deliveries of that flit.
